// File: rtl/router_reset_sequencer.sv
// Staggered per-router reset generator with power-on and software-requested sequences.
// Define ROUTER_RST_STATUS_EN to add the saturating seq_count status output.
module router_reset_sequencer #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned STAGGER     = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sw_rst_req,
  input  logic [N_CH-1:0] ch_mask,
  output logic            sw_rst_ack,
  output logic [N_CH-1:0] ch_rst_n,
  output logic            busy,
`ifdef ROUTER_RST_STATUS_EN
  output logic [15:0]     seq_count,
`endif
  output logic            done
);

  localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_CH - 1);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] StagLast = CNT_W'(STAGGER - 1);
  localparam bit SingleHold = (HOLD_CYCLES <= 1);

  typedef enum logic [1:0] {StIdle, StHold, StRelease} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic [N_CH-1:0]   mask_q;
  logic              sw_flag_q;
  logic              req_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StHold;
      cnt_q      <= '0;
      idx_q      <= '0;
      mask_q     <= '1;
      sw_flag_q  <= 1'b0;
      req_q      <= 1'b0;
      ch_rst_n   <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      sw_rst_ack <= 1'b0;
    end else begin
      req_q      <= sw_rst_req;
      done       <= 1'b0;
      sw_rst_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sw_rst_req && !req_q) begin
            if (ch_mask == '0) begin
              done       <= 1'b1;
              sw_rst_ack <= 1'b1;
            end else begin
              mask_q    <= ch_mask;
              ch_rst_n  <= ch_rst_n & ~ch_mask;
              busy      <= 1'b1;
              sw_flag_q <= 1'b1;
              idx_q     <= '0;
              // The accepting edge is itself the first hold edge.
              if (SingleHold) begin
                state_q <= StRelease;
                cnt_q   <= '0;
              end else begin
                state_q <= StHold;
                cnt_q   <= CNT_W'(1);
              end
            end
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            state_q <= StRelease;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StRelease: begin
          if (cnt_q == '0 && mask_q[idx_q]) begin
            ch_rst_n[idx_q] <= 1'b1;
          end
          // The final slot ends one edge after its release, regardless of STAGGER.
          if (idx_q == LastIdx) begin
            if (cnt_q != '0) begin
              state_q    <= StIdle;
              cnt_q      <= '0;
              idx_q      <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              sw_rst_ack <= sw_flag_q;
              sw_flag_q  <= 1'b0;
            end else begin
              cnt_q <= CNT_W'(1);
            end
          end else if (cnt_q == StagLast) begin
            cnt_q <= '0;
            idx_q <= idx_q + IdxW'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StHold;
      endcase
    end
  end

`ifdef ROUTER_RST_STATUS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      seq_count <= '0;
    end else if (done && seq_count != 16'hFFFF) begin
      seq_count <= seq_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_reset_sequencer.sv
// Randomised self-checking bench for router_reset_sequencer against a timing-rule model.
module tb_router_reset_sequencer;
  localparam int N = 4;
  localparam int H = 8;
  localparam int S = 2;

  logic         clk;
  logic         reset;
  logic         sw_rst_req;
  logic [N-1:0] ch_mask;
  logic         sw_rst_ack;
  logic [N-1:0] ch_rst_n;
  logic         busy;
  logic         done;
`ifdef ROUTER_RST_STATUS_EN
  logic [15:0]  seq_count;
`endif

  int checks = 0;
  int errors = 0;

  router_reset_sequencer #(
    .N_CH(N), .HOLD_CYCLES(H), .STAGGER(S), .CNT_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_rst_req (sw_rst_req),
    .ch_mask    (ch_mask),
    .sw_rst_ack (sw_rst_ack),
    .ch_rst_n   (ch_rst_n),
    .busy       (busy),
`ifdef ROUTER_RST_STATUS_EN
    .seq_count  (seq_count),
`endif
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is an edge count k from its cycle-0 edge; channel i releases at
  // k = H + i*S, and the sequence ends at k = H + (N-1)*S + 1.
  bit           started = 0;
  bit           in_seq;
  int           k;
  logic [N-1:0] m_mask;
  bit           m_sw;
  bit           req_prev;
  logic [N-1:0] exp_ch;
  bit           exp_busy, exp_done, exp_ack;
  int           exp_cnt;

  initial forever begin
    @(posedge clk);
    if (!reset) exp_cnt = 0;
    else if (exp_done && exp_cnt < 65535) exp_cnt++;
    exp_done = 0;
    exp_ack  = 0;
    if (!reset) begin
      in_seq   = 1;
      k        = 0;
      m_mask   = '1;
      m_sw     = 0;
      exp_ch   = '0;
      exp_busy = 1;
      req_prev = 0;
    end else begin
      if (in_seq) begin
        for (int i = 0; i < N; i++)
          if (m_mask[i] && k == H + i * S) exp_ch[i] = 1'b1;
        if (k == H + (N - 1) * S + 1) begin
          in_seq   = 0;
          exp_busy = 0;
          exp_done = 1;
          exp_ack  = m_sw;
          m_sw     = 0;
        end
        k++;
      end else if (sw_rst_req && !req_prev) begin
        if (ch_mask == '0) begin
          exp_done = 1;
          exp_ack  = 1;
        end else begin
          in_seq   = 1;
          k        = 1;
          m_mask   = ch_mask;
          m_sw     = 1;
          exp_ch   = exp_ch & ~ch_mask;
          exp_busy = 1;
        end
      end
      req_prev = sw_rst_req;
    end
    started = 1;
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("ch_rst_n", 32'(ch_rst_n), 32'(exp_ch));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("sw_rst_ack", 32'(sw_rst_ack), 32'(exp_ack));
`ifdef ROUTER_RST_STATUS_EN
      chk("seq_count", 32'(seq_count), 32'(exp_cnt));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    sw_rst_req = 1'b0;
    ch_mask    = '0;
    repeat (5) step();
    chk("rst_ch", 32'(ch_rst_n), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_done", 32'(done), 32'h0);

    // Power-on: releases at edges 8,10,12,14; done at 15.
    reset = 1'b1;
    for (int e = 0; e <= 15; e++) begin
      step();
      if (e == 7)  chk("po_e7", 32'(ch_rst_n), 32'h0);
      if (e == 8)  chk("po_e8", 32'(ch_rst_n), 32'h1);
      if (e == 10) chk("po_e10", 32'(ch_rst_n), 32'h3);
      if (e == 14) chk("po_e14", 32'({busy, ch_rst_n}), 32'h1F);
      if (e == 15) chk("po_e15", 32'({done, busy, ch_rst_n}), 32'h2F);
    end
    repeat (2) step();

    // Masked sw sequence.
    sw_rst_req = 1'b1;
    ch_mask    = 4'b0101;
    step();
    chk("sw_accept", 32'({busy, ch_rst_n}), 32'h1A);
    sw_rst_req = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      step();
      if (e == 8)  chk("sw_e8", 32'(ch_rst_n), 32'hB);
      if (e == 12) chk("sw_e12", 32'(ch_rst_n), 32'hF);
      if (e == 15) chk("sw_ack", 32'({sw_rst_ack, done}), 32'h3);
    end
    step();
    chk("sw_ack_end", 32'(sw_rst_ack), 32'h0);

    // Empty-mask request.
    sw_rst_req = 1'b1;
    ch_mask    = '0;
    step();
    chk("m0_pulse", 32'({sw_rst_ack, done, busy, ch_rst_n}), 32'h6F);
    sw_rst_req = 1'b0;
    step();
    chk("m0_after", 32'({sw_rst_ack, done, busy}), 32'h0);

    // Request raised during power-on and held: ignored until it re-rises.
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (3) step();
    sw_rst_req = 1'b1;
    ch_mask    = 4'b0010;
    repeat (25) step();
    chk("held_idle", 32'({busy, ch_rst_n}), 32'h0F);
    sw_rst_req = 1'b0;
    step();
    sw_rst_req = 1'b1;
    step();
    chk("rerise", 32'({busy, ch_rst_n}), 32'h1D);
    sw_rst_req = 1'b0;

    // Reset at edge 11 of that sw sequence.
    for (int e = 1; e <= 10; e++) step();
    reset = 1'b0;
    step();
    chk("abort_ch", 32'({sw_rst_ack, ch_rst_n}), 32'h0);
    reset = 1'b1;
    for (int e = 0; e <= 15; e++) begin
      step();
      chk("abort_noack", 32'(sw_rst_ack), 32'h0);
      if (e == 15) chk("abort_done", 32'({done, ch_rst_n}), 32'h1F);
    end

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 299) != 0);
      sw_rst_req = ($urandom_range(0, 3) == 0) ? ~sw_rst_req : sw_rst_req;
      ch_mask    = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      step();
    end
    reset      = 1'b1;
    sw_rst_req = 1'b0;
    repeat (30) step();
    chk("final_idle", 32'({busy, ch_rst_n}), 32'h0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
